// File: rtl/pmem_arb_pkg.sv
// Shared types and helpers for the program memory arbiter.
// Holds the width defaults and the round-robin pick function.
package pmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_CORES  = 8;
    localparam int IDX_W      = 3;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of elig scanning ptr, ptr+1, ... wrapping at n.
    function automatic pick_t rr_pick(
        input logic [MAX_CORES-1:0] elig,
        input logic [IDX_W-1:0]     ptr,
        input int                   n
    );
        pick_t r;
        int    c;
        r = '0;
        for (int k = 0; k < MAX_CORES; k++) begin
            c = int'(ptr) + k;
            if (c >= n) c = c - n;
            if (k < n && !r.found && elig[c[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = c[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection with its priority pointer.
// The pointer moves to one past the winner after each grant.
module rr_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] eligible,
    output logic                 grant_found,
    output logic [IDX_W-1:0]     grant_idx
);

    logic [IDX_W-1:0]     ptr;
    logic [MAX_CORES-1:0] elig_ext;
    logic [IDX_W:0]       nxt;
    pick_t                pick;

    // Widen the request mask and pick the next winner.
    always_comb begin
        elig_ext = '0;
        elig_ext[NUM_CORES-1:0] = eligible;
        pick = rr_pick(elig_ext, ptr, NUM_CORES);
    end

    assign grant_found = pick.found;
    assign grant_idx   = pick.idx;
    assign nxt         = {1'b0, pick.idx} + (IDX_W+1)'(1);

    // Advance the pointer past the winner, wrapping to core 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (pick.found) begin
            if (nxt == (IDX_W+1)'(NUM_CORES))
                ptr <= '0;
            else
                ptr <= nxt[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/program_memory_arbiter.sv
// Shares one combinational program ROM among several fetch ports.
// Two-stage pipe: arbitrate+coalesce, then steer ROM data back.
module program_memory_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_valid,
    output logic [NUM_CORES*DATA_W-1:0] core_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_data,
    output logic                        busy
);

    logic [NUM_CORES-1:0] serve_q;
    logic [NUM_CORES-1:0] serve_d;
    logic [NUM_CORES-1:0] eligible;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    win_addr;

    // A core in flight or just answered still holds its old request.
    assign eligible = core_req & ~serve_q & ~core_valid;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .eligible    (eligible),
        .grant_found (grant_found),
        .grant_idx   (grant_idx)
    );

    // Select the winning core's address.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (IDX_W'(i) == grant_idx)
                win_addr = core_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Every eligible core fetching the winner's address rides along.
    always_comb begin
        serve_d = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            serve_d[i] = grant_found && eligible[i] &&
                (core_addr[i*ADDR_W +: ADDR_W] == win_addr);
        end
    end

    // Stage 1: register the ROM address and the serve mask.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr <= '0;
            serve_q  <= '0;
            busy     <= 1'b0;
        end else if (grant_found) begin
            mem_addr <= win_addr;
            serve_q  <= serve_d;
            busy     <= 1'b1;
        end else begin
            serve_q  <= '0;
            busy     <= 1'b0;
        end
    end

    // Stage 2: capture ROM data into each served core's slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_valid <= '0;
            core_rdata <= '0;
        end else begin
            core_valid <= serve_q;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (serve_q[i])
                    core_rdata[i*DATA_W +: DATA_W] <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Bench for program_memory_arbiter: directed cases with literal
// expectations plus random traffic against a behavioural model.
module tb_program_memory_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   core_req;
    logic [N*8-1:0] core_addr;
    logic [N-1:0]   core_valid;
    logic [N*8-1:0] core_rdata;
    logic [7:0]     mem_addr;
    logic [7:0]     mem_data;
    logic           busy;

    int checks = 0;
    int errors = 0;

    program_memory_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (8),
        .DATA_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_valid (core_valid),
        .core_rdata (core_rdata),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign mem_data = mem_addr ^ 8'hA5;

    typedef struct packed {
        int             ptr;
        logic [N-1:0]   s2;
        logic [7:0]     mem;
        logic           busy;
        logic [N-1:0]   valid;
        logic [N-1:0][7:0] rd;
    } mstate_t;

    mstate_t m;
    bit      m_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] rom(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    // One cycle of the spec: answer last grant, then grant anew.
    function automatic mstate_t model_step(input mstate_t s,
        input logic rst_n, input logic [N-1:0] req,
        input logic [N*8-1:0] addr);
        mstate_t      n;
        logic [N-1:0] elig;
        bit           found;
        int           w;
        int           c;
        n = s;
        if (!rst_n) begin
            n = '0;
            return n;
        end
        n.valid = s.s2;
        for (int i = 0; i < N; i++)
            if (s.s2[i]) n.rd[i] = rom(s.mem);
        elig  = req & ~s.s2 & ~s.valid;
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < N; k++) begin
            c = (s.ptr + k) % N;
            if (!found && elig[c]) begin
                found = 1'b1;
                w     = c;
            end
        end
        n.s2 = '0;
        if (found) begin
            n.mem = addr[w*8 +: 8];
            for (int j = 0; j < N; j++)
                if (elig[j] && addr[j*8 +: 8] == n.mem) n.s2[j] = 1'b1;
            n.busy = 1'b1;
            n.ptr  = (w + 1) % N;
        end else begin
            n.busy = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_step(m, reset, core_req, core_addr);
        if (!reset) m_on <= 1'b1;
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_on) begin
            chk("mem_addr", 32'(mem_addr), 32'(m.mem));
            chk("busy", 32'(busy), 32'(m.busy));
            chk("core_valid", 32'(core_valid), 32'(m.valid));
            for (int i = 0; i < N; i++)
                chk($sformatf("rdata%0d", i),
                    32'(core_rdata[i*8 +: 8]), 32'(m.rd[i]));
        end
    end

    task automatic set_req(input int i, input logic r,
                           input logic [7:0] a);
        core_req[i] = r;
        core_addr[i*8 +: 8] = a;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        core_req  = '0;
        core_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        core_req = '0;
        repeat (n) @(negedge clk);
    endtask

    bit [N-1:0] pend;
    int         k;

    initial begin
        reset     = 1'b0;
        core_req  = '0;
        core_addr = '0;

        // Single requester, reset state and latency.
        do_reset();
        chk("rst_valid", 32'(core_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_rdata", core_rdata, 32'h0);
        set_req(2, 1'b1, 8'h04);
        @(negedge clk);
        chk("t1_mem_addr", 32'(mem_addr), 32'h04);
        chk("t1_busy_c1", 32'(busy), 32'h1);
        chk("t1_valid_c1", 32'(core_valid), 32'h0);
        @(negedge clk);
        chk("t1_valid_c2", 32'(core_valid), 32'h4);
        chk("t1_rdata2", 32'(core_rdata[23:16]), 32'hA1);
        chk("t1_busy_c2", 32'(busy), 32'h0);
        set_req(2, 1'b0, 8'h04);
        @(negedge clk);
        chk("t1_valid_c3", 32'(core_valid), 32'h0);
        idle(2);

        // Four distinct continuous requesters: strict rotation.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h10 + i));
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                k = (c - 2) % N;
                chk("t2_valid", 32'(core_valid), 32'(1 << k));
                chk("t2_rdata", 32'(core_rdata[k*8 +: 8]),
                    32'((8'h10 + k) ^ 8'hA5));
            end
        end
        idle(4);

        // All cores on one address: a single coalesced access.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h21);
        @(negedge clk);
        chk("t3_mem_addr", 32'(mem_addr), 32'h21);
        chk("t3_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("t3_valid", 32'(core_valid), 32'hF);
        chk("t3_rdata", core_rdata, 32'h84848484);
        core_req = '0;
        @(negedge clk);
        chk("t3_valid_c3", 32'(core_valid), 32'h0);
        chk("t3_busy_c3", 32'(busy), 32'h0);
        set_req(0, 1'b1, 8'h40);
        set_req(1, 1'b1, 8'h41);
        @(negedge clk);
        chk("t3_ptr_after", 32'(mem_addr), 32'h41);
        idle(4);

        // Partial coalescing: 0 and 3 share, 1 follows.
        do_reset();
        set_req(0, 1'b1, 8'h09);
        set_req(3, 1'b1, 8'h09);
        set_req(1, 1'b1, 8'h0D);
        @(negedge clk);
        chk("t4_mem_addr", 32'(mem_addr), 32'h09);
        @(negedge clk);
        chk("t4_valid_c2", 32'(core_valid), 32'h9);
        chk("t4_rdata0", 32'(core_rdata[7:0]), 32'hAC);
        chk("t4_rdata3", 32'(core_rdata[31:24]), 32'hAC);
        set_req(0, 1'b0, 8'h09);
        set_req(3, 1'b0, 8'h09);
        @(negedge clk);
        chk("t4_valid_c3", 32'(core_valid), 32'h2);
        chk("t4_rdata1", 32'(core_rdata[15:8]), 32'hA8);
        idle(4);

        // One core holding its request: refetch every third cycle.
        do_reset();
        set_req(1, 1'b1, 8'h30);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("t5_valid", 32'(core_valid),
                (c == 2 || c == 5) ? 32'h2 : 32'h0);
            chk("t5_busy", 32'(busy),
                (c == 1 || c == 4) ? 32'h1 : 32'h0);
            if (c == 6) set_req(1, 1'b0, 8'h30);
        end
        idle(2);

        // Reset while stage 2 is occupied drops the access.
        do_reset();
        set_req(0, 1'b1, 8'h55);
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(core_valid), 32'h0);
        chk("t6_busy0", 32'(busy), 32'h0);
        chk("t6_mem_addr", 32'(mem_addr), 32'h0);
        chk("t6_rdata", core_rdata, 32'h0);
        reset = 1'b1;
        set_req(0, 1'b1, 8'h66);
        set_req(1, 1'b1, 8'h77);
        @(negedge clk);
        chk("t6_ptr_zero", 32'(mem_addr), 32'h66);
        idle(4);

        // Random traffic obeying the requester contract.
        pend = '0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if ($urandom % 300 == 0) begin
                reset = 1'b0;
                pend  = '0;
            end else begin
                reset = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (pend[i] && m.valid[i]) pend[i] = 1'b0;
                else if (pend[i] && $urandom % 32 == 0) pend[i] = 1'b0;
                else if (!pend[i] && reset && $urandom % 3 != 0) begin
                    pend[i] = 1'b1;
                    if ($urandom % 8 == 0)
                        core_addr[i*8 +: 8] = 8'($urandom);
                    else
                        core_addr[i*8 +: 8] = 8'(8'h20 + $urandom % 4);
                end
            end
            core_req = pend;
        end
        reset = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
